regwrite_queue: RTL and testbench
=================================

# regwrite_queue

Write-back buffer that sits directly upstream of the 32x32 register file write port. It accepts register-write requests from the execute/memory stages over a valid/ready handshake and holds them in a small in-order FIFO. It drains at most one entry per clock into the register file's WriteRegister/WriteData/RegWrite inputs. It can also forward pending (not yet written) data to the two read-address lookups, so operand fetch never sees stale register contents.

## Interface
- DEPTH, 4, queue entries; power of two, >= 2
- WIDTH, 32, data width
- ADDRW, 5, register address width
- Clk  in  1  clock; all state updates on the positive edge
- Reset  in  1  synchronous, active-high reset
- InValid  in  1  producer has a write request
- InReady  out  1  queue can accept a request this cycle
- InRegister  in  ADDRW  destination register of the request
- InData  in  WIDTH  data of the request
- DrainHold  in  1  when high, suppress draining this cycle
- WriteRegister  out  ADDRW  to regfile: head entry address
- WriteData  out  WIDTH  to regfile: head entry data
- RegWrite  out  1  to regfile write enable
- LookupRegister1, LookupRegister2  in  ADDRW  addresses being read by operand fetch
- Fwd1Hit, Fwd2Hit  out  1  pending entry matches the lookup (only with WBQ_BYPASS_EN)
- Fwd1Data, Fwd2Data  out  WIDTH  forwarded data
- Count  out  log2(DEPTH)+1  number of stored entries
- Empty  out  1  Count == 0

## Operation
- Accept: request accepted when InValid & InReady at a posedge. InReady = (Count != DEPTH); there is no pass-through when full, even if a drain occurs in the same cycle.
- Register 0 filter: accepted requests with InRegister == 0 complete the handshake but are discarded. They are not stored and do not change Count.
- Storage: circular buffer with read/write pointers that wrap modulo DEPTH. Order is strictly FIFO.
- Drain: WriteRegister/WriteData are driven combinationally from the head entry, or all zeros when Empty. RegWrite = !Empty & !DrainHold. When RegWrite is high at a posedge, the regfile stores the head entry and the queue pops it on the same edge.
- Simultaneous accept and drain (not full): Count is unchanged and both pointers advance.
- Forwarding: each lookup compares against all valid entries. On multiple matches, the youngest matching entry wins. LookupRegister == 0 never hits. The request being accepted in the current cycle is not visible to lookups until the next cycle. On a miss, FwdNData = 0.
- Reset: pointers and Count cleared and pending entries discarded, including when asserted mid-drain. After reset: RegWrite=0, WriteRegister=0, WriteData=0, InReady=1, Empty=1, Count=0, Fwd1Hit=Fwd2Hit=0, Fwd1Data=Fwd2Data=0. The entry storage array itself need not be cleared.

## Timing
- Enqueue-to-RegWrite latency: 1 cycle. An entry accepted at edge N is presented with RegWrite=1 after edge N and written into the regfile at edge N+1, provided the queue was empty and DrainHold is low.
- Full throughput: one accept and one drain per cycle in steady state.
- DrainHold asserted at a posedge: no pop, and the head is held stable.
- Count, Empty, and InReady change only on posedges, or on the Reset edge.
- Forwarding outputs are purely combinational from the lookups and the stored state. There is no added latency.

## Configuration
- WBQ_BYPASS_EN defined: forwarding compare logic is present, as described above.
- WBQ_BYPASS_EN undefined: no compare logic. Fwd1Hit, Fwd2Hit, Fwd1Data, and Fwd2Data are tied to 0; the ports remain so that integration is unchanged. Operand fetch must stall until Empty before reading.

## Test plan
- Reset, then one request: InRegister=2, InData=42. Required: RegWrite high for exactly 1 cycle with WriteRegister=2 and WriteData=42; the regfile then reads 42 at register 2; Count returns to 0.
- DrainHold=1, then 4 requests to registers 1, 3, 4, 5 (data 10, 30, 40, 50). Required: InReady=0 and Count=4; a 5th request is not accepted. Then release DrainHold. Required: drain order 1, 3, 4, 5 on consecutive cycles.
- Request to register 0 with data 25. Required: Count stays 0 and RegWrite stays 0; the regfile register 0 still reads 0.
- DrainHold=1, then enqueue register 4 with 15 followed by register 4 with 99; lookup 4 on both ports. Required: Fwd1Hit=Fwd2Hit=1 with data 99. Lookup 6 gives Hit=0 and Data=0. Without WBQ_BYPASS_EN, all Fwd outputs are 0.
- Queue of 3 entries, continuous accept and drain for 8 cycles. Required: Count stays 3, pointers wrap, and data exits in order.
- Reset asserted with 2 pending entries. Required: on the next edge Count=0, RegWrite=0, and InReady=1; the regfile is never written with the discarded entries.

Source files
------------

// File: rtl/regwrite_queue.sv
// ---------------------------------------------------------------------------
// regwrite_queue
//
// Write-back buffer placed directly in front of the 32x32 register file write
// port. Register-write requests arrive over a valid/ready handshake and are
// held in a small in-order circular FIFO. At most one entry per clock drains
// into the register file through WriteRegister/WriteData/RegWrite. Requests
// targeting register 0 complete the handshake but are dropped, because that
// register is hard-wired to zero.
//
// Optional feature (macro WBQ_BYPASS_EN):
//   defined   : both lookup ports are compared against every pending entry.
//               The youngest match is forwarded so operand fetch never sees
//               stale register contents.
//   undefined : no compare logic. The Fwd* outputs are tied to zero, and
//               operand fetch has to wait for Empty before it reads.
//
// Parameters
//   DEPTH  number of queue entries (power of two, >= 2)
//   WIDTH  data width
//   ADDRW  register address width
//
// Ports
//   Clk                  clock, all state changes on the rising edge
//   Reset                synchronous, active-high reset
//   InValid / InReady    request handshake (InReady = not full)
//   InRegister / InData  request destination and data
//   DrainHold            suppresses draining while high
//   WriteRegister        to regfile: head entry address (0 when empty)
//   WriteData            to regfile: head entry data (0 when empty)
//   RegWrite             to regfile: write enable
//   LookupRegister1/2    operand-fetch read addresses
//   Fwd1Hit / Fwd2Hit    a pending entry matches the lookup address
//   Fwd1Data / Fwd2Data  forwarded data (0 on a miss)
//   Count                number of stored entries
//   Empty                Count == 0
// ---------------------------------------------------------------------------
module regwrite_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int ADDRW = 5
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [ADDRW-1:0]         InRegister,
  input  logic [WIDTH-1:0]         InData,
  input  logic                     DrainHold,
  output logic [ADDRW-1:0]         WriteRegister,
  output logic [WIDTH-1:0]         WriteData,
  output logic                     RegWrite,
  input  logic [ADDRW-1:0]         LookupRegister1,
  input  logic [ADDRW-1:0]         LookupRegister2,
  output logic                     Fwd1Hit,
  output logic                     Fwd2Hit,
  output logic [WIDTH-1:0]         Fwd1Data,
  output logic [WIDTH-1:0]         Fwd2Data,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  // Entry storage. It is never reset: only the slots covered by
  // [rd_ptr, rd_ptr+count_q) hold meaningful data.
  logic [ADDRW-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] mem_dat [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count_q;

  logic accept;
  logic store;
  logic pop;

  // There is no pass-through when full, even if the head pops on the same
  // edge. This keeps InReady a pure function of registered state.
  assign Empty   = (count_q == '0);
  assign InReady = (count_q != FULL_COUNT);
  assign Count   = count_q;

  assign accept = InValid & InReady;
  // Register 0 writes finish the handshake but never occupy a slot.
  assign store  = accept & (InRegister != '0);

  // RegWrite is also gated by Reset. An entry that is being discarded by a
  // reset therefore never reaches the register file on that same edge.
  assign RegWrite = !Empty & !DrainHold & !Reset;
  assign pop      = RegWrite;

  assign WriteRegister = Empty ? '0 : mem_reg[rd_ptr];
  assign WriteData     = Empty ? '0 : mem_dat[rd_ptr];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (store) begin
      mem_reg[wr_ptr] <= InRegister;
      mem_dat[wr_ptr] <= InData;
    end
  end

`ifdef WBQ_BYPASS_EN
  // The scan walks from the oldest entry to the youngest, so a later match
  // overwrites an earlier one and the youngest pending write wins. A request
  // that is still being accepted is not yet in storage, so a lookup cannot
  // see it until the following cycle.
  logic [PW:0]   fwd_off;
  logic [PW-1:0] fwd_idx;

  always_comb begin
    Fwd1Hit  = 1'b0;
    Fwd2Hit  = 1'b0;
    Fwd1Data = '0;
    Fwd2Data = '0;
    fwd_off  = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_off = (PW+1)'(i);
      fwd_idx = rd_ptr + fwd_off[PW-1:0];
      if (fwd_off < count_q) begin
        if ((LookupRegister1 != '0) && (mem_reg[fwd_idx] == LookupRegister1)) begin
          Fwd1Hit  = 1'b1;
          Fwd1Data = mem_dat[fwd_idx];
        end
        if ((LookupRegister2 != '0) && (mem_reg[fwd_idx] == LookupRegister2)) begin
          Fwd2Hit  = 1'b1;
          Fwd2Data = mem_dat[fwd_idx];
        end
      end
    end
  end
`else
  // The ports are kept so that integration stays the same in both builds.
  // The lookup addresses are intentionally left unused here.
  logic unused_lookup;
  assign unused_lookup = ^{LookupRegister1, LookupRegister2};

  assign Fwd1Hit  = 1'b0;
  assign Fwd2Hit  = 1'b0;
  assign Fwd1Data = '0;
  assign Fwd2Data = '0;
`endif

endmodule

// File: tb/tb_regwrite_queue.sv
// ---------------------------------------------------------------------------
// tb_regwrite_queue
//
// Testbench for regwrite_queue. The reference model is a pair of queues,
// holding the pending (register, data) writes in arrival order, plus an
// expected register-file image. A raw 32x32 register file is kept alongside
// it and is written from the DUT's RegWrite/WriteRegister/WriteData outputs.
// ---------------------------------------------------------------------------
module tb_regwrite_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int ADDRW = 5;

  logic             Clk;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [ADDRW-1:0] InRegister;
  logic [WIDTH-1:0] InData;
  logic             DrainHold;
  logic [ADDRW-1:0] WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic             RegWrite;
  logic [ADDRW-1:0] LookupRegister1;
  logic [ADDRW-1:0] LookupRegister2;
  logic             Fwd1Hit;
  logic             Fwd2Hit;
  logic [WIDTH-1:0] Fwd1Data;
  logic [WIDTH-1:0] Fwd2Data;
  logic [2:0]       Count;
  logic             Empty;

  regwrite_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDRW(ADDRW)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InRegister(InRegister), .InData(InData), .DrainHold(DrainHold),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .LookupRegister1(LookupRegister1), .LookupRegister2(LookupRegister2),
    .Fwd1Hit(Fwd1Hit), .Fwd2Hit(Fwd2Hit), .Fwd1Data(Fwd1Data), .Fwd2Data(Fwd2Data),
    .Count(Count), .Empty(Empty)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [ADDRW-1:0] q_reg[$];
  logic [WIDTH-1:0] q_dat[$];
  logic [WIDTH-1:0] exp_rf [32];
  logic [WIDTH-1:0] rf [32];

  // Raw register file fed by the DUT; register 0 is stored like any other
  // so that a write to it would be visible.
  always @(posedge Clk)
    if (RegWrite) rf[WriteRegister] <= WriteData;

  // Expected forwarding result: youngest pending write to the address wins.
  function automatic void fwd_model(input logic [ADDRW-1:0] la,
                                    output logic hit, output logic [WIDTH-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (la != 0)
      for (int i = 0; i < q_reg.size(); i++)
        if (q_reg[i] == la) begin hit = 1'b1; d = q_dat[i]; end
`ifndef WBQ_BYPASS_EN
    hit = 1'b0;
    d   = '0;
`endif
  endfunction

  // One clock edge. The model takes the inputs present at the edge:
  // reset clears it; otherwise the head pops (if not held) and the new
  // request is appended when there was room before the edge.
  task automatic tick();
    bit acc;
    @(posedge Clk);
    if (Reset) begin
      q_reg.delete();
      q_dat.delete();
    end else begin
      acc = InValid && (q_reg.size() != DEPTH);
      if (q_reg.size() != 0 && !DrainHold) begin
        exp_rf[q_reg[0]] = q_dat[0];
        void'(q_reg.pop_front());
        void'(q_dat.pop_front());
      end
      if (acc && InRegister != 0) begin
        q_reg.push_back(InRegister);
        q_dat.push_back(InData);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b0; DrainHold = 1'b0;
    InRegister = '0; InData = '0;
    LookupRegister1 = 5'd2; LookupRegister2 = 5'd3;
    tick(); tick();
    Reset = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset RegWrite: got %0b expected 0", RegWrite); end
    checks++; if (WriteRegister !== '0) begin errors++; $display("FAIL reset WriteRegister: got %0d expected 0", WriteRegister); end
    checks++; if (WriteData !== '0) begin errors++; $display("FAIL reset WriteData: got %0h expected 0", WriteData); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset InReady: got %0b expected 1", InReady); end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL reset Empty: got %0b expected 1", Empty); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset Count: got %0d expected 0", Count); end
    checks++; if ({Fwd1Hit, Fwd2Hit, Fwd1Data, Fwd2Data} !== '0) begin errors++;
      $display("FAIL reset Fwd: got %0b %0b %0h %0h expected all 0", Fwd1Hit, Fwd2Hit, Fwd1Data, Fwd2Data); end
  endtask

  task automatic test_single();
    InValid = 1'b1; InRegister = 5'd2; InData = 32'd42;
    tick();
    InValid = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL single RegWrite: got %0b expected 1", RegWrite); end
    checks++; if (WriteRegister !== 5'd2) begin errors++; $display("FAIL single WriteRegister: got %0d expected 2", WriteRegister); end
    checks++; if (WriteData !== 32'd42) begin errors++; $display("FAIL single WriteData: got %0d expected 42", WriteData); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single RegWrite after: got %0b expected 0", RegWrite); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL single Count after: got %0d expected 0", Count); end
    checks++; if (rf[2] !== 32'd42) begin errors++; $display("FAIL single regfile[2]: got %0d expected 42", rf[2]); end
  endtask

  task automatic test_full();
    logic [ADDRW-1:0] regs [4];
    logic [WIDTH-1:0] dats [4];
    regs[0] = 5'd1; regs[1] = 5'd3; regs[2] = 5'd4; regs[3] = 5'd5;
    dats[0] = 32'd10; dats[1] = 32'd30; dats[2] = 32'd40; dats[3] = 32'd50;
    DrainHold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      InValid = 1'b1; InRegister = regs[k]; InData = dats[k];
      tick();
    end
    InRegister = 5'd7; InData = 32'd70;
    #1;
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL full InReady: got %0b expected 0", InReady); end
    checks++; if (Count !== 3'd4) begin errors++; $display("FAIL full Count: got %0d expected 4", Count); end
    tick();
    checks++; if (Count !== 3'd4) begin errors++; $display("FAIL full 5th rejected Count: got %0d expected 4", Count); end
    InValid = 1'b0; DrainHold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, regs[k], dats[k]}) begin errors++;
        $display("FAIL full drain %0d: got we=%0b reg=%0d data=%0d expected we=1 reg=%0d data=%0d",
                 k, RegWrite, WriteRegister, WriteData, regs[k], dats[k]); end
      tick();
    end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL full Empty after drain: got %0b expected 1", Empty); end
  endtask

  task automatic test_reg0();
    InValid = 1'b1; InRegister = 5'd0; InData = 32'd25;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reg0 InReady: got %0b expected 1", InReady); end
    tick();
    InValid = 1'b0;
    #1;
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reg0 Count: got %0d expected 0", Count); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reg0 RegWrite: got %0b expected 0", RegWrite); end
    tick();
    checks++; if (rf[0] !== 32'd0) begin errors++; $display("FAIL reg0 regfile[0]: got %0d expected 0", rf[0]); end
  endtask

  task automatic test_forward();
    logic             eh1, eh2;
    logic [WIDTH-1:0] ed1, ed2;
    DrainHold = 1'b1;
    InValid = 1'b1; InRegister = 5'd4; InData = 32'd15;
    tick();
    InData = 32'd99;
    LookupRegister1 = 5'd4; LookupRegister2 = 5'd4;
    #1;
    // The request with 99 is still in flight, so the lookup sees 15.
    fwd_model(LookupRegister1, eh1, ed1);
    checks++; if ({Fwd1Hit, Fwd1Data} !== {eh1, ed1}) begin errors++;
      $display("FAIL fwd inflight: got %0b/%0d expected %0b/%0d", Fwd1Hit, Fwd1Data, eh1, ed1); end
    tick();
    InValid = 1'b0;
    #1;
    fwd_model(LookupRegister1, eh1, ed1);
    fwd_model(LookupRegister2, eh2, ed2);
    checks++; if ({Fwd1Hit, Fwd1Data} !== {eh1, ed1}) begin errors++;
      $display("FAIL fwd port1 youngest: got %0b/%0d expected %0b/%0d", Fwd1Hit, Fwd1Data, eh1, ed1); end
    checks++; if ({Fwd2Hit, Fwd2Data} !== {eh2, ed2}) begin errors++;
      $display("FAIL fwd port2 youngest: got %0b/%0d expected %0b/%0d", Fwd2Hit, Fwd2Data, eh2, ed2); end
    LookupRegister1 = 5'd6; LookupRegister2 = 5'd0;
    #1;
    checks++; if ({Fwd1Hit, Fwd1Data, Fwd2Hit, Fwd2Data} !== '0) begin errors++;
      $display("FAIL fwd miss: got %0b/%0d %0b/%0d expected all 0", Fwd1Hit, Fwd1Data, Fwd2Hit, Fwd2Data); end
    DrainHold = 1'b0;
    tick(); tick();
    checks++; if (rf[4] !== 32'd99) begin errors++; $display("FAIL fwd regfile[4]: got %0d expected 99", rf[4]); end
  endtask

  task automatic test_back_to_back();
    logic [ADDRW-1:0] er;
    logic [WIDTH-1:0] ed;
    DrainHold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      InValid = 1'b1; InRegister = 5'(8 + k); InData = 32'(100 + k);
      tick();
    end
    DrainHold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      InValid = 1'b1; InRegister = 5'(11 + k); InData = 32'(200 + k);
      er = (k < 3) ? 5'(8 + k) : 5'(8 + k);
      ed = (k < 3) ? 32'(100 + k) : 32'(200 + k - 3);
      #1;
      checks++; if (Count !== 3'd3) begin errors++; $display("FAIL b2b Count cycle %0d: got %0d expected 3", k, Count); end
      checks++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, er, ed}) begin errors++;
        $display("FAIL b2b order cycle %0d: got we=%0b reg=%0d data=%0d expected we=1 reg=%0d data=%0d",
                 k, RegWrite, WriteRegister, WriteData, er, ed); end
      tick();
    end
    InValid = 1'b0;
    tick(); tick(); tick();
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL b2b Empty: got %0b expected 1", Empty); end
  endtask

  task automatic test_reset_pending();
    DrainHold = 1'b1;
    InValid = 1'b1; InRegister = 5'd20; InData = 32'hdead0001; tick();
    InRegister = 5'd21; InData = 32'hdead0002; tick();
    InValid = 1'b0; DrainHold = 1'b0; Reset = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rstpend RegWrite during reset: got %0b expected 0", RegWrite); end
    tick();
    Reset = 1'b0;
    #1;
    checks++; if ({Count, RegWrite, InReady, Empty} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin errors++;
      $display("FAIL rstpend state: got cnt=%0d we=%0b rdy=%0b empty=%0b expected 0 0 1 1", Count, RegWrite, InReady, Empty); end
    tick();
    checks++; if ({rf[20], rf[21]} !== {exp_rf[20], exp_rf[21]}) begin errors++;
      $display("FAIL rstpend regfile: got %0h %0h expected %0h %0h", rf[20], rf[21], exp_rf[20], exp_rf[21]); end
  endtask

  task automatic test_random();
    logic             eh1, eh2;
    logic [WIDTH-1:0] ed1, ed2;
    logic [ADDRW-1:0] er;
    logic [WIDTH-1:0] ed;
    for (int n = 0; n < 400; n++) begin
      Reset           = ($urandom_range(0, 99) < 2);
      InValid         = ($urandom_range(0, 99) < 60);
      DrainHold       = ($urandom_range(0, 99) < 30);
      InRegister      = 5'($urandom_range(0, 7));
      InData          = $urandom;
      LookupRegister1 = 5'($urandom_range(0, 7));
      LookupRegister2 = 5'($urandom_range(0, 7));
      #1;
      fwd_model(LookupRegister1, eh1, ed1);
      fwd_model(LookupRegister2, eh2, ed2);
      er = (q_reg.size() != 0) ? q_reg[0] : '0;
      ed = (q_dat.size() != 0) ? q_dat[0] : '0;
      checks++; if (Count !== 3'(q_reg.size())) begin errors++; $display("FAIL rand Count @%0d: got %0d expected %0d", n, Count, q_reg.size()); end
      checks++; if (InReady !== (q_reg.size() != DEPTH)) begin errors++; $display("FAIL rand InReady @%0d: got %0b", n, InReady); end
      checks++; if (Empty !== (q_reg.size() == 0)) begin errors++; $display("FAIL rand Empty @%0d: got %0b", n, Empty); end
      checks++; if (RegWrite !== (q_reg.size() != 0 && !DrainHold && !Reset)) begin errors++; $display("FAIL rand RegWrite @%0d: got %0b", n, RegWrite); end
      checks++; if ({WriteRegister, WriteData} !== {er, ed}) begin errors++;
        $display("FAIL rand head @%0d: got %0d/%0h expected %0d/%0h", n, WriteRegister, WriteData, er, ed); end
      checks++; if ({Fwd1Hit, Fwd1Data} !== {eh1, ed1}) begin errors++;
        $display("FAIL rand fwd1 @%0d: got %0b/%0h expected %0b/%0h", n, Fwd1Hit, Fwd1Data, eh1, ed1); end
      checks++; if ({Fwd2Hit, Fwd2Data} !== {eh2, ed2}) begin errors++;
        $display("FAIL rand fwd2 @%0d: got %0b/%0h expected %0b/%0h", n, Fwd2Hit, Fwd2Data, eh2, ed2); end
      tick();
    end
    Reset = 1'b0; InValid = 1'b0; DrainHold = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    for (int r = 0; r < 32; r++) begin
      checks++; if (rf[r] !== exp_rf[r]) begin errors++; $display("FAIL final regfile[%0d]: got %0h expected %0h", r, rf[r], exp_rf[r]); end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin rf[r] = '0; exp_rf[r] = '0; end
    test_reset();
    test_single();
    test_full();
    test_reg0();
    test_forward();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
